// File: rtl/alu_operand_fetch_if.sv
// Operand-fetch stage handshake bundle: instruction in, write-back in, ALU operation out.
// The slave modport is the fetch stage; the master modport is the surrounding datapath.
interface alu_operand_fetch_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        func;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] dest;
    logic              illegal;
    logic [7:0]        ill_cnt;

    modport master (
        output in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, func, a, b, dest, illegal, ill_cnt
    );

    modport slave (
        input  in_valid, instr, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, func, a, b, dest, illegal, ill_cnt
    );
endinterface

// File: rtl/alu_operand_fetch.sv
// R-type decode + register-file read feeding the ALU; 1-cycle latency, write-back bypassed into the read.
// Backpressure: in_ready = !out_valid | out_ready (single output register, no skid buffer).
module alu_operand_fetch #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input logic               clk,
    input logic               rst,
    alu_operand_fetch_if.slave bus
);
    typedef struct packed {
        logic [5:0]        func;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ADDR_W-1:0] dest;
    } alu_op_t;

    logic [DATA_W-1:0] regs [NREGS];
    alu_op_t           op_q;
    alu_op_t           op_d;
    logic              out_vld_q;
    logic              ill_q;
    logic [7:0]        ill_cnt_q;

    logic              accept;
    logic              legal;
    logic [ADDR_W-1:0] rs_idx;
    logic [ADDR_W-1:0] rt_idx;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              unused_shamt;

    assign unused_shamt = ^bus.instr[10:6];

    assign bus.in_ready = rst | ~out_vld_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    assign legal        = (bus.instr[31:26] == 6'b000000);
    assign rs_idx       = ADDR_W'(bus.instr[25:21]);
    assign rt_idx       = ADDR_W'(bus.instr[20:16]);

    // r0 reads as zero even when a write-back targets it; otherwise the in-flight write-back wins.
    always_comb begin
        rd_a = '0;
        if (rs_idx != '0) begin
            if (bus.wb_en && bus.wb_addr == rs_idx)
                rd_a = bus.wb_data;
            else if (32'(rs_idx) < NREGS)
                rd_a = regs[rs_idx];
        end
    end

    always_comb begin
        rd_b = '0;
        if (rt_idx != '0) begin
            if (bus.wb_en && bus.wb_addr == rt_idx)
                rd_b = bus.wb_data;
            else if (32'(rt_idx) < NREGS)
                rd_b = regs[rt_idx];
        end
    end

    always_comb begin
        op_d.func = bus.instr[5:0];
        op_d.a    = rd_a;
        op_d.b    = rd_b;
        op_d.dest = ADDR_W'(bus.instr[15:11]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            op_q      <= '0;
            ill_q     <= 1'b0;
            ill_cnt_q <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            ill_q <= accept & ~legal;
            if (accept && !legal && ill_cnt_q != 8'hFF)
                ill_cnt_q <= ill_cnt_q + 8'd1;

            // A legal accept overrides consumption so back-to-back ops keep out_valid high.
            if (accept && legal) begin
                out_vld_q <= 1'b1;
                op_q      <= op_d;
            end else if (out_vld_q && bus.out_ready) begin
                out_vld_q <= 1'b0;
            end

            if (bus.wb_en && bus.wb_addr != '0 && 32'(bus.wb_addr) < NREGS)
                regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.func      = op_q.func;
    assign bus.a         = op_q.a;
    assign bus.b         = op_q.b;
    assign bus.dest      = op_q.dest;
    assign bus.illegal   = ill_q;
    assign bus.ill_cnt   = ill_cnt_q;
endmodule

// File: tb/tb_alu_operand_fetch.sv
// Randomized plus directed bench for alu_operand_fetch against a transaction-level reference model.
module tb_alu_operand_fetch;
    logic clk;
    logic rst;

    alu_operand_fetch_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    alu_operand_fetch #(.DATA_W(8), .ADDR_W(5), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] func;
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] dest;
    } op_t;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] m_regs [32];
    op_t        pending [$];
    bit         m_ill;
    int         m_cnt;
    bit         m_zeroed;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int rd, input int funct);
        logic [31:0] w;
        w = '0;
        w[31:26] = 6'(op);
        w[25:21] = 5'(rs);
        w[20:16] = 5'(rt);
        w[15:11] = 5'(rd);
        w[10:6]  = 5'($urandom_range(0, 31));
        w[5:0]   = 6'(funct);
        return w;
    endfunction

    // Operand value as seen by the instruction: r0 is zero, a same-cycle write-back is visible.
    function automatic logic [7:0] model_read(input int idx);
        if (idx == 0) return 8'h00;
        if (bus.wb_en && int'(bus.wb_addr) == idx) return bus.wb_data;
        return m_regs[idx];
    endfunction

    task automatic model_edge();
        bit   acc;
        op_t  o;
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            pending.delete();
            m_ill    = 1'b0;
            m_cnt    = 0;
            m_zeroed = 1'b1;
            return;
        end
        acc   = bus.in_valid && (pending.size() == 0 || bus.out_ready);
        m_ill = acc && (bus.instr[31:26] != 6'd0);
        if (m_ill && m_cnt < 255) m_cnt++;
        if (pending.size() != 0 && bus.out_ready) pending.pop_front();
        if (acc && !m_ill) begin
            o.func = bus.instr[5:0];
            o.a    = model_read(int'(bus.instr[25:21]));
            o.b    = model_read(int'(bus.instr[20:16]));
            o.dest = bus.instr[15:11];
            pending.push_back(o);
            m_zeroed = 1'b0;
        end
        if (bus.wb_en && bus.wb_addr != 5'd0) m_regs[bus.wb_addr] = bus.wb_data;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(bus.out_valid), 32'(pending.size() != 0));
        if (pending.size() != 0) begin
            chk("func", 32'(bus.func), 32'(pending[0].func));
            chk("a",    32'(bus.a),    32'(pending[0].a));
            chk("b",    32'(bus.b),    32'(pending[0].b));
            chk("dest", 32'(bus.dest), 32'(pending[0].dest));
        end else if (m_zeroed) begin
            chk("op_zero", {bus.func, bus.a, bus.b, bus.dest}, 32'd0);
        end
        chk("illegal", 32'(bus.illegal), 32'(m_ill));
        chk("ill_cnt", 32'(bus.ill_cnt), 32'(m_cnt));
    endtask

    // Inputs are set by the caller before tick; in_ready is checked once they settle.
    task automatic tick();
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(rst || pending.size() == 0 || bus.out_ready));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit iv, input logic [31:0] ins, input bit we, input int wa, input int wd, input bit ordy);
        bus.in_valid  = iv;
        bus.instr     = ins;
        bus.wb_en     = we;
        bus.wb_addr   = 5'(wa);
        bus.wb_data   = 8'(wd);
        bus.out_ready = ordy;
    endtask

    initial begin
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        m_ill = 1'b0; m_cnt = 0; m_zeroed = 1'b1;
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // Basic ADD r3 = r1 + r2
        drive(0, 32'h0, 1, 1, 'h05, 1); tick();
        drive(0, 32'h0, 1, 2, 'h03, 1); tick();
        drive(1, 32'h00221820, 0, 0, 0, 1); tick();
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_func",  32'(bus.func), 32'h20);
        chk("t1_a",     32'(bus.a), 32'h05);
        chk("t1_b",     32'(bus.b), 32'h03);
        chk("t1_dest",  32'(bus.dest), 32'd3);

        // Same-cycle write-back bypass
        drive(1, mk(0, 4, 0, 5, 'h22), 1, 4, 'hAA, 1); tick();
        chk("t2_a", 32'(bus.a), 32'hAA);
        chk("t2_b", 32'(bus.b), 32'h00);

        // Stall: held op must not pick up a later write-back
        drive(1, mk(0, 1, 2, 6, 'h24), 0, 0, 0, 1); tick();
        drive(1, mk(0, 1, 4, 7, 'h25), 1, 1, 'h77, 0); tick();
        drive(1, mk(0, 1, 4, 7, 'h25), 0, 0, 0, 0); tick();
        chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("t3_held_a", 32'(bus.a), 32'h05);
        chk("t3_held_dest", 32'(bus.dest), 32'd6);
        drive(1, mk(0, 1, 4, 7, 'h25), 0, 0, 0, 1); tick();
        chk("t3_b2b_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_b2b_a", 32'(bus.a), 32'h77);
        chk("t3_b2b_dest", 32'(bus.dest), 32'd7);
        drive(0, 32'h0, 0, 0, 0, 1); tick();

        // Illegal opcode and counter saturation
        drive(1, 32'h8C220000, 0, 0, 0, 1); tick();
        chk("t4_illegal", 32'(bus.illegal), 32'd1);
        chk("t4_cnt", 32'(bus.ill_cnt), 32'd1);
        chk("t4_valid", 32'(bus.out_valid), 32'd0);
        drive(0, 32'h0, 0, 0, 0, 1); tick();
        chk("t4_pulse_end", 32'(bus.illegal), 32'd0);
        for (int i = 0; i < 300; i++) begin
            drive(1, mk($urandom_range(1, 63), 1, 2, 3, 'h20), 0, 0, 0, 1);
            tick();
        end
        chk("t4_sat", 32'(bus.ill_cnt), 32'd255);

        // r0 ignores writes
        drive(0, 32'h0, 1, 0, 'hFF, 1); tick();
        drive(1, mk(0, 0, 0, 1, 'h20), 0, 0, 0, 1); tick();
        chk("t5_a", 32'(bus.a), 32'h00);

        // Reset while stalled
        drive(1, mk(0, 1, 1, 2, 'h20), 0, 0, 0, 0); tick();
        drive(0, 32'h0, 0, 0, 0, 0); tick();
        chk("t6_pre_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1; tick();
        chk("t6_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        drive(1, mk(0, 1, 0, 2, 'h20), 0, 0, 0, 1); tick();
        chk("t6_r1", 32'(bus.a), 32'h00);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0,
                  mk(($urandom_range(0, 7) == 0) ? $urandom_range(1, 63) : 0,
                     $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 63)),
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255),
                  $urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
